// File: rtl/scan_tick_pkg.sv
// Shared types and defaults for the scan tick prescaler.
// Optional one-shot mode is enabled with the SCAN_TICK_ONESHOT_EN macro.
package scan_tick_pkg;

  localparam int          DEFAULT_W      = 16;
  localparam int unsigned DEFAULT_RELOAD = 49999;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/scan_tick_gen_if.sv
// Reload-value write port of the scan tick prescaler.
// Handshake: a transfer happens on a posedge where load_valid && load_ready; the
// master holds load_value stable while load_valid=1 and load_ready=0.
interface scan_tick_gen_if #(
  parameter int W = 16
);
  logic         load_valid;
  logic [W-1:0] load_value;
  logic         load_ready;

  modport master (output load_valid, output load_value, input load_ready);
  modport slave  (input load_valid, input load_value, output load_ready);
endinterface

// File: rtl/scan_tick_gen_down_counter_core.sv
// Loadable down-counter that saturates at zero; load has priority over decrement.
module down_counter_core #(
  parameter int           W       = 16,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         dec_en,
  input  logic         load_en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);
  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= RST_VAL;
    end else if (load_en) begin
      count_q <= load_val;
    end else if (dec_en && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);
endmodule

// File: rtl/scan_tick_gen.sv
// Programmable prescaler producing the one-cycle enable strobe for the digit-scan counter.
// Define SCAN_TICK_ONESHOT_EN to add the oneshot input (one tick per run request).
module scan_tick_gen
  import scan_tick_pkg::*;
#(
  parameter int          W              = DEFAULT_W,
  parameter int unsigned DEFAULT_RELOAD = scan_tick_pkg::DEFAULT_RELOAD
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
`ifdef SCAN_TICK_ONESHOT_EN
  input  logic            oneshot,
`endif
  scan_tick_gen_if.slave  load_if,
  output logic            tick,
  output logic            busy,
  output logic [W-1:0]    count,
  output state_t          state_dbg
);
  localparam logic [W-1:0] RELOAD_RST = W'(DEFAULT_RELOAD);

  state_t       state_q, state_d;
  logic [W-1:0] reload_q, reload_d;
  logic         tick_q, tick_d;
  logic         ready_q, ready_d;
  logic         accept;
  logic         start_ok;
  logic         cnt_load_en, cnt_dec_en, cnt_zero;
  logic [W-1:0] cnt_load_val, cnt_q;

`ifdef SCAN_TICK_ONESHOT_EN
  logic oneshot_q, oneshot_d;
  logic rearm_q, rearm_d;
`endif

  down_counter_core #(.W(W), .RST_VAL(RELOAD_RST)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .dec_en   (cnt_dec_en),
    .load_en  (cnt_load_en),
    .load_val (cnt_load_val),
    .count    (cnt_q),
    .zero     (cnt_zero)
  );

  always_comb begin
    accept       = load_if.load_valid && ready_q;
    state_d      = state_q;
    tick_d       = 1'b0;
    cnt_load_en  = 1'b0;
    cnt_dec_en   = 1'b0;
    reload_d     = accept ? load_if.load_value : reload_q;
    cnt_load_val = reload_d;
    ready_d      = !accept;
    start_ok     = 1'b1;
`ifdef SCAN_TICK_ONESHOT_EN
    start_ok  = rearm_q;
    oneshot_d = oneshot_q;
    rearm_d   = run ? rearm_q : 1'b1;
`endif

    case (state_q)
      ST_IDLE: begin
        cnt_load_en = accept;
        if (run && start_ok) begin
          state_d = ST_RUN;
`ifdef SCAN_TICK_ONESHOT_EN
          oneshot_d = oneshot;
`endif
        end
      end
      ST_RUN: begin
        // Dropping run wins over a wrap: the zero stays frozen for HOLD.
        if (!run) begin
          state_d = ST_HOLD;
        end else if (cnt_zero) begin
          cnt_load_en = 1'b1;
          tick_d      = 1'b1;
`ifdef SCAN_TICK_ONESHOT_EN
          if (oneshot_q) begin
            state_d = ST_IDLE;
            rearm_d = 1'b0;
          end
`endif
        end else begin
          cnt_dec_en = 1'b1;
        end
      end
      ST_HOLD: begin
        cnt_load_en = accept;
        if (run) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      reload_q <= RELOAD_RST;
      tick_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      tick_q   <= tick_d;
      ready_q  <= ready_d;
    end
  end

`ifdef SCAN_TICK_ONESHOT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oneshot_q <= 1'b0;
      rearm_q   <= 1'b1;
    end else begin
      oneshot_q <= oneshot_d;
      rearm_q   <= rearm_d;
    end
  end
`endif

  assign tick              = tick_q;
  assign busy              = (state_q == ST_RUN);
  assign count             = cnt_q;
  assign state_dbg         = state_q;
  assign load_if.load_ready = ready_q;
endmodule

// File: doc/scan_tick_gen.md
Name: scan_tick_gen

Overview:
- Programmable down-counting prescaler that produces the single-cycle enable strobe consumed by the display controller's digit-scan up-counter.
- It is the producing end of the counter's enable interface: it decides when the scan counter advances.
- The reload value is written through a valid/ready load port. Run/hold control gates tick generation.

Parameters:
W, 16, width of the down-counter and the reload value
DEFAULT_RELOAD, 49999, reload value after reset; tick period = reload+1 clk cycles

Ports:
clk  input  1  system clock, all logic on posedge
rst_n  input  1  reset; asynchronous, active-low
run  input  1  level; 1 = count and generate ticks, 0 = hold
load_valid  input  1  reload-write request
load_value  input  W  new reload value, sampled when load_valid && load_ready
load_ready  output  1  block can accept a load this cycle
tick  output  1  registered one-cycle enable strobe to the scan counter
busy  output  1  high while FSM is in RUN
count  output  W  current down-counter value (debug/observation)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; count=DEFAULT_RELOAD; reload_reg=DEFAULT_RELOAD.
  - tick=0; busy=0; load_ready=1.
  - Reset asserted mid-operation aborts immediately; no tick is emitted during or on exit from reset.
- FSM states: IDLE, RUN, HOLD.
  - IDLE: count=reload_reg. run=1 -> RUN next cycle; the first decrement happens in the first RUN cycle.
  - RUN: busy=1; count decrements by 1 each cycle.
    - count==0 -> next cycle count=reload_reg, tick=1 for exactly that cycle.
    - run=0 -> HOLD next cycle; this takes priority over a wrap in the same cycle, so no tick is emitted and count stays 0.
  - HOLD: count frozen; tick=0. run=1 -> RUN, resuming from the frozen value. A frozen 0 wraps and ticks on the first RUN cycle.
  - No return path to IDLE except reset, or one-shot completion (see Optional Feature).
- Tick timing: in steady RUN, tick period = reload_reg+1 cycles, duty = 1 cycle.
- reload_reg=0: count stays 0 and tick is high every RUN cycle (continuous enable).
- Load handshake:
  - A transfer occurs when load_valid && load_ready.
  - load_ready drops to 0 for exactly one cycle after each accept, then returns to 1.
  - load_value must be held stable while load_valid=1 and load_ready=0.
- Effect of an accepted load:
  - Always written to reload_reg.
  - In IDLE/HOLD, also copied into count in the same edge.
  - In RUN, count is unchanged. The new value takes effect at the next wrap.
  - Load accepted in the same cycle as a wrap: the wrap uses the new load_value.
- Arithmetic: unsigned W-bit. Decrement is never applied at 0 (wrap-to-reload instead), so count never underflows to all-ones.
- All outputs registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: SCAN_TICK_ONESHOT_EN
- Defined:
  - Adds input port oneshot (1 bit), sampled on the IDLE->RUN transition.
  - If sampled 1, the FSM goes RUN -> IDLE on the cycle tick is asserted, giving exactly one tick per run request.
  - count reloads to reload_reg.
  - run must be deasserted and reasserted to start again (run held high in IDLE does not restart until it has been seen low).
- Not defined: port absent; behaviour is always periodic as described above.

Decomposition:
- Package scan_tick_pkg:
  - state typedef (IDLE, RUN, HOLD) with 2-bit encoding.
  - DEFAULT_W=16 and DEFAULT_RELOAD=49999 constants.
- Sub-module down_counter_core(W): loadable down-counter.
  - Inputs: dec_en, load_en, load_val.
  - Outputs: count, zero flag.
- The top instantiates down_counter_core and holds the FSM, reload_reg, tick register and load handshake.

Test Plan:
- Reset with DEFAULT_RELOAD=4, run=1 from cycle 2 -> first tick 6 cycles after run rises, then every 5 cycles; count sequence 4,3,2,1,0,4.
- Load 2 in IDLE (load_valid 1 cycle) -> load_ready=0 next cycle then 1; count=2 immediately; subsequent tick period 3.
- In RUN with reload 4, load 1 at count==2 -> next two ticks at spacings of 3 (remaining count) then 2 cycles.
- run=0 at count==0 -> no tick, HOLD with count=0; run=1 three cycles later -> tick on first RUN cycle.
- Reload 0, run=1 -> tick high every cycle. Assert rst_n=0 mid-stream -> tick=0 and count=DEFAULT_RELOAD within the reset cycle.
- With SCAN_TICK_ONESHOT_EN, oneshot=1, reload 3, run=1 held -> exactly one tick, state IDLE; toggle run 0->1 -> one more tick.
